remote_key_ctrl: RTL
====================

Name: remote_key_ctrl

Overview:
- Key-event controller between the IR frame decoder (`data_en`/`data`/`repeat_en` outputs) and application logic (display, LED, menu control).
- Turns raw decoded frames and NEC repeat frames into a clean stream of press, auto-repeat and release events.
- Owns hold-timing, the release timeout and a small event FIFO with a valid/ready handshake, so consumers never see raw repeat bursts.

Parameters:
- `CLK_FREQ`, 50_000_000: `sys_clk` frequency in Hz; ms tick period = `CLK_FREQ/1000` cycles.
- `RELEASE_MS`, 150: ms without any frame or repeat before the held key is declared released.
- `HOLD_DELAY`, 4: repeat frames after a press before the first auto-repeat event.
- `REPEAT_DIV`, 2: after `HOLD_DELAY`, one auto-repeat event per `REPEAT_DIV` repeat frames.
- `FIFO_DEPTH`, 4: event FIFO entries; power of two, at least 2.

Ports:
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: synchronous reset, active-high.
- `data_en` in 1: one-cycle pulse, new full frame decoded.
- `data` in 8: key code, valid when `data_en`=1.
- `repeat_en` in 1: one-cycle pulse, repeat frame received.
- `evt_valid` out 1: FIFO head event available.
- `evt_ready` in 1: consumer accepts head event when `evt_valid`&`evt_ready`.
- `evt_code` out 8: key code of head event.
- `evt_type` out 2: event kind at head; 01 press, 10 auto-repeat, 11 release.
- `key_held` out 1: level, high while the controller is in HELD.
- `cur_code` out 8: code of the currently or last held key.
- `ovf` out 1: sticky, set when an event is dropped because the FIFO is full.
- `ovf_clr` in 1: clears `ovf`.

Behaviour:

Reset and clock
- Single clock `sys_clk`; synchronous active-high reset `sys_rst` on every register.
- Reset values: `evt_valid`=0, `evt_code`=0, `evt_type`=0, `key_held`=0, `cur_code`=0, `ovf`=0.
- Reset also clears FIFO pointers, the ms prescaler and all counters, and forces state IDLE.
- Reset mid-hold produces no release event.

ms tick
- Free-running prescaler, 0..`CLK_FREQ/1000`-1.
- `ms_tick`=1 for one cycle at the terminal count.

FSM: two states, IDLE and HELD
- IDLE, `data_en`=1:
  - `cur_code`<=`data`.
  - Push {`data`, 01}.
  - `rpt_cnt`<=0, `div_cnt`<=0.
  - `to_cnt`<=`RELEASE_MS`.
  - Go to HELD.
- IDLE, `repeat_en`=1: ignored (orphan repeat).
- HELD, `data_en`=1, any code including the same code: treated as a new press.
  - Push {`data`, 01}; update `cur_code`.
  - Reload `to_cnt`; clear `rpt_cnt` and `div_cnt`.
  - Stay in HELD.
  - No release is emitted for the previous key.
- HELD, `repeat_en`=1:
  - Reload `to_cnt`; `rpt_cnt` increments, saturating at 255.
  - If `rpt_cnt`+1 >= `HOLD_DELAY`: `div_cnt` increments modulo `REPEAT_DIV`.
  - When `div_cnt`==0 before the increment, push {`cur_code`, 10}.
  - First auto-repeat therefore occurs on repeat frame number `HOLD_DELAY`, then every `REPEAT_DIV` frames.
- HELD, `ms_tick`=1 with no `data_en`/`repeat_en` that cycle:
  - `to_cnt` decrements.
  - When it reaches 0: push {`cur_code`, 11} and go to IDLE.
- `key_held` is registered and equals (state==HELD).

Priority in one cycle
- `data_en` > `repeat_en` > timeout decrement.
- A reload always beats an expiry on the same cycle.

Event FIFO
- Depth `FIFO_DEPTH`, 10-bit entries {code, type}; first-word fall-through.
- `evt_*` reflect the head combinationally from registered storage.
- Push when full without a simultaneous pop: event dropped, `ovf`<=1.
- Push and pop on the same cycle when full: both succeed, no overflow.
- Push and pop on the same cycle when empty: the pop is ignored because `evt_valid`=0; the push lands and `evt_valid`=1 next cycle.
- At most one push per cycle (guaranteed by the priority rules).
- Latency: input pulse to `evt_valid`=1 is 1 cycle when the FIFO is empty.

Overflow flag
- `ovf_clr` and a set on the same cycle: the set wins.

Test Plan:
All scenarios use `CLK_FREQ`=10000 (10-cycle ms), `RELEASE_MS`=3, `HOLD_DELAY`=2, `REPEAT_DIV`=2, `FIFO_DEPTH`=4, `evt_ready`=1 unless stated.

1. `data_en` with `data`=0x45 -> next cycle `evt_valid`=1, {0x45, 01}, `key_held`=1. No further input -> after 3 ms ticks, {0x45, 11} and `key_held`=0.
2. Press 0x18, then 5 `repeat_en` pulses 1 ms apart -> events: press, repeat on frames 2 and 4, and a release 3 ms after the last repeat. Exactly 4 events total.
3. `repeat_en` pulses in IDLE -> no events, `key_held` stays 0.
4. Press 0x0C, then within hold a `data_en` with 0x5E -> press 0x0C, press 0x5E, then release 0x5E only; `cur_code`=0x5E.
5. `evt_ready`=0, 5 presses -> 4 queued, `ovf`=1. Assert `ovf_clr` -> `ovf`=0. Drain -> the 4 codes come out in order.
6. Assert `sys_rst` mid-hold, during `to_cnt`=1 -> all outputs 0, no release event afterwards. Also: `repeat_en` coincident with the expiry `ms_tick` -> no release, timeout reloaded.

Source files
------------

// File: rtl/remote_key_ctrl.sv
// remote_key_ctrl
//   Turns decoded IR frames (full frames and NEC repeat frames) into a clean
//   stream of press / auto-repeat / release events, queued in a small
//   first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   data_en, data[7:0]    new full frame pulse and its key code
//   repeat_en             repeat frame pulse
//   evt_valid/evt_ready   FIFO head handshake
//   evt_code[7:0]         key code at FIFO head
//   evt_type[1:0]         01 press, 10 auto-repeat, 11 release
//   key_held              high while a key is held
//   cur_code[7:0]         code of the current or last held key
//   ovf, ovf_clr          sticky event-drop flag and its clear
//
// state | meaning
// IDLE  | no key held, orphan repeat frames ignored
// HELD  | key held, counting repeats and the release timeout

module remote_key_ctrl #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int RELEASE_MS = 150,
    parameter int HOLD_DELAY = 4,
    parameter int REPEAT_DIV = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       data_en,
    input  logic [7:0] data,
    input  logic       repeat_en,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [7:0] evt_code,
    output logic [1:0] evt_type,
    output logic       key_held,
    output logic [7:0] cur_code,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int TICK_DIV = CLK_FREQ / 1000;
    localparam int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W     = $clog2(RELEASE_MS + 1);
    localparam int DIV_W    = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);

    localparam logic [1:0] EV_PRESS   = 2'b01;
    localparam logic [1:0] EV_REPEAT  = 2'b10;
    localparam logic [1:0] EV_RELEASE = 2'b11;

    typedef enum logic {IDLE, HELD} state_t;

    state_t           state;
    logic [PS_W-1:0]  ps_cnt;
    logic             ms_tick;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       rpt_cnt;
    logic [7:0]       rpt_next;
    logic [DIV_W-1:0] div_cnt;
    logic             in_hold;
    logic             push_en;
    logic [9:0]       push_word;

    // ms prescaler
    assign ms_tick = (ps_cnt == PS_W'(TICK_DIV - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            ps_cnt <= '0;
        else if (ms_tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + 1'b1;
    end

    // Count including the frame arriving now; auto-repeat window opens at HOLD_DELAY.
    assign rpt_next = (rpt_cnt == 8'hFF) ? 8'hFF : rpt_cnt + 8'd1;
    assign in_hold  = ({1'b0, rpt_cnt} + 9'd1) >= 9'(HOLD_DELAY);

    // Event generation mirrors the FSM priority: data_en > repeat_en > timeout.
    always_comb begin
        push_en   = 1'b0;
        push_word = '0;
        if (data_en) begin
            push_en   = 1'b1;
            push_word = {data, EV_PRESS};
        end else if (state == HELD) begin
            if (repeat_en) begin
                if (in_hold && div_cnt == '0) begin
                    push_en   = 1'b1;
                    push_word = {cur_code, EV_REPEAT};
                end
            end else if (ms_tick && to_cnt <= TO_W'(1)) begin
                push_en   = 1'b1;
                push_word = {cur_code, EV_RELEASE};
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= IDLE;
            key_held <= 1'b0;
            cur_code <= '0;
            rpt_cnt  <= '0;
            div_cnt  <= '0;
            to_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_en) begin
                        cur_code <= data;
                        rpt_cnt  <= '0;
                        div_cnt  <= '0;
                        to_cnt   <= TO_W'(RELEASE_MS);
                        state    <= HELD;
                        key_held <= 1'b1;
                    end
                end
                HELD: begin
                    if (data_en) begin
                        // Re-press of any code restarts the hold without a release.
                        cur_code <= data;
                        rpt_cnt  <= '0;
                        div_cnt  <= '0;
                        to_cnt   <= TO_W'(RELEASE_MS);
                    end else if (repeat_en) begin
                        to_cnt  <= TO_W'(RELEASE_MS);
                        rpt_cnt <= rpt_next;
                        if (in_hold)
                            div_cnt <= (div_cnt == DIV_W'(REPEAT_DIV - 1)) ? '0 : div_cnt + 1'b1;
                    end else if (ms_tick) begin
                        if (to_cnt <= TO_W'(1)) begin
                            to_cnt   <= '0;
                            state    <= IDLE;
                            key_held <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

    // Event FIFO: extra pointer bit separates full from empty.
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;

    assign evt_valid = (wr_ptr != rd_ptr);
    assign fifo_full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = evt_valid && evt_ready;
    assign push_ok   = push_en && (!fifo_full || pop);
    assign {evt_code, evt_type} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // A drop on the same cycle as a clear keeps the flag set.
            if (push_en && fifo_full && !pop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

endmodule
